// File: rtl/micro_sequencer_if.sv
// Sequencer-side bundle: sequencing inputs, table programming port and datapath/status outputs.
// The driver (datapath/programmer) uses master; the sequencer uses slave.
interface micro_sequencer_if #(
  parameter int UADDR_W     = 6,
  parameter int CTRL_W      = 24,
  parameter int OPC_W       = 4,
  parameter int CC_W        = 2,
  parameter int STACK_DEPTH = 4
);
  localparam int UW   = CTRL_W + 3 + UADDR_W;
  localparam int SP_W = $clog2(STACK_DEPTH + 1);

  logic               stall;
  logic [OPC_W-1:0]   opcode;
  logic [CC_W-1:0]    cmp;
  logic               int_req;
  logic               prog_we;
  logic [1:0]         prog_sel;
  logic [UADDR_W-1:0] prog_addr;
  logic [UW-1:0]      prog_data;
  logic [CTRL_W-1:0]  ctrl;
  logic [UADDR_W-1:0] upc;
  logic               int_ack;
  logic               halted;
  logic               stack_err;
  logic [SP_W-1:0]    sp;

  modport master (
    output stall, opcode, cmp, int_req, prog_we, prog_sel, prog_addr, prog_data,
    input  ctrl, upc, int_ack, halted, stack_err, sp
  );

  modport slave (
    input  stall, opcode, cmp, int_req, prog_we, prog_sel, prog_addr, prog_data,
    output ctrl, upc, int_ack, halted, stack_err, sp
  );
endinterface

// File: rtl/micro_sequencer.sv
// Programmable microcode sequencer with dispatch tables, interrupt vector and return stack.
// ctrl is an asynchronous read of store[upc]; stall freezes upc, stack and interrupt-ack generation.
module micro_sequencer #(
  parameter int UADDR_W     = 6,
  parameter int CTRL_W      = 24,
  parameter int OPC_W       = 4,
  parameter int CC_W        = 2,
  parameter int STACK_DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  micro_sequencer_if.slave bus
);
  localparam int UW   = CTRL_W + 3 + UADDR_W;
  localparam int SP_W = $clog2(STACK_DEPTH + 1);
  localparam int SI_W = (STACK_DEPTH > 1) ? $clog2(STACK_DEPTH) : 1;

  typedef enum logic [2:0] {
    SEQ_NEXT     = 3'b000,
    SEQ_DISP_OP  = 3'b001,
    SEQ_DISP_CC  = 3'b010,
    SEQ_DISP_INT = 3'b011,
    SEQ_CALL     = 3'b100,
    SEQ_RET      = 3'b101,
    SEQ_BR_CC    = 3'b110,
    SEQ_HALT     = 3'b111
  } seq_op_e;

  logic [UW-1:0]      store_q  [2**UADDR_W];
  logic [UADDR_W-1:0] optab_q  [2**OPC_W];
  logic [UADDR_W-1:0] cctab_q  [2**CC_W];
  logic [UADDR_W-1:0] intvec_q;
  logic [UADDR_W-1:0] stack_q  [STACK_DEPTH];

  logic [UADDR_W-1:0] upc_q, upc_d;
  logic [SP_W-1:0]    sp_q, sp_d;
  logic               err_q, err_d;
  logic               ack_q, ack_d;
  logic               push_en;

  logic [UW-1:0]      cur_word;
  seq_op_e            seq_op;
  logic [UADDR_W-1:0] nxt;
  logic [UADDR_W-1:0] upc_inc;
  logic [SI_W-1:0]    push_idx;
  logic [SI_W-1:0]    pop_idx;

  assign cur_word = store_q[upc_q];
  assign seq_op   = seq_op_e'(cur_word[UADDR_W+2:UADDR_W]);
  assign nxt      = cur_word[UADDR_W-1:0];
  assign upc_inc  = upc_q + 1'b1;
  assign push_idx = SI_W'(sp_q);
  assign pop_idx  = SI_W'(sp_q - 1'b1);

  always_comb begin
    upc_d   = upc_q;
    sp_d    = sp_q;
    err_d   = err_q;
    ack_d   = 1'b0;
    push_en = 1'b0;
    if (!bus.stall) begin
      case (seq_op)
        SEQ_NEXT:    upc_d = nxt;
        SEQ_DISP_OP: upc_d = optab_q[bus.opcode];
        SEQ_DISP_CC: upc_d = cctab_q[bus.cmp];
        SEQ_DISP_INT: begin
          if (bus.int_req) begin
            upc_d = intvec_q;
            ack_d = 1'b1;
          end else begin
            upc_d = nxt;
          end
        end
        SEQ_CALL: begin
          // A full stack still takes the jump; only the return address is lost.
          upc_d = nxt;
          if (sp_q == SP_W'(STACK_DEPTH)) begin
            err_d = 1'b1;
          end else begin
            push_en = 1'b1;
            sp_d    = sp_q + 1'b1;
          end
        end
        SEQ_RET: begin
          if (sp_q == '0) begin
            upc_d = '0;
            err_d = 1'b1;
          end else begin
            upc_d = stack_q[pop_idx];
            sp_d  = sp_q - 1'b1;
          end
        end
        SEQ_BR_CC:   upc_d = (bus.cmp != '0) ? nxt : upc_inc;
        SEQ_HALT:    upc_d = upc_q;
        default:     upc_d = upc_q;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      upc_q <= '0;
      sp_q  <= '0;
      err_q <= 1'b0;
      ack_q <= 1'b0;
    end else begin
      upc_q <= upc_d;
      sp_q  <= sp_d;
      err_q <= err_d;
      ack_q <= ack_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push_en && !rst) begin
      stack_q[push_idx] <= upc_inc;
    end
  end

  // Tables are never cleared by rst; a write coinciding with rst still lands.
  always_ff @(posedge clk) begin
    if (bus.prog_we) begin
      case (bus.prog_sel)
        2'b00:   store_q[bus.prog_addr]            <= bus.prog_data;
        2'b01:   optab_q[bus.prog_addr[OPC_W-1:0]] <= bus.prog_data[UADDR_W-1:0];
        2'b10:   cctab_q[bus.prog_addr[CC_W-1:0]]  <= bus.prog_data[UADDR_W-1:0];
        default: intvec_q                          <= bus.prog_data[UADDR_W-1:0];
      endcase
    end
  end

  assign bus.ctrl      = cur_word[UW-1:UADDR_W+3];
  assign bus.upc       = upc_q;
  assign bus.int_ack   = ack_q;
  assign bus.halted    = (seq_op == SEQ_HALT);
  assign bus.stack_err = err_q;
  assign bus.sp        = sp_q;
endmodule

// File: doc/micro_sequencer.md
Name: micro_sequencer

Overview:
- Parametrised, programmable microcode sequencer. It is the next-generation control unit for the multi-cycle, bus-based datapath.
- It holds a loadable microcode store, an opcode dispatch table, a condition-code dispatch table and an interrupt vector.
- It adds a microsubroutine call/return stack, stall support, halt, and synchronous reset of the micro-PC.
- It drives a CTRL_W-bit control word to the datapath every cycle and sequences on opcode, compare result and interrupt request.

Parameters:
- UADDR_W, 6: micro-PC / microcode address width; store depth is 2**UADDR_W.
- CTRL_W, 24: control-word width driven to the datapath.
- OPC_W, 4: opcode width; must satisfy OPC_W <= UADDR_W.
- CC_W, 2: compare-result width; must satisfy CC_W <= UADDR_W.
- STACK_DEPTH, 4: microsubroutine return stack entries (>=1).
- Derived: UW = CTRL_W + 3 + UADDR_W (microword width).

Ports:
- clk  in  1  clock.
- rst  in  1  reset, synchronous, active-high.
- stall  in  1  hold micro-PC and stack this cycle.
- opcode  in  OPC_W  instruction opcode (from IR).
- cmp  in  CC_W  compare-result register.
- int_req  in  1  level interrupt request (already gated by IE).
- prog_we  in  1  table write strobe.
- prog_sel  in  2  target: 00 microcode, 01 opcode table, 10 CC table, 11 interrupt vector.
- prog_addr  in  UADDR_W  table index; upper bits ignored for the smaller tables.
- prog_data  in  UW  write data; tables and vector use [UADDR_W-1:0].
- ctrl  out  CTRL_W  control word of the current microword.
- upc  out  UADDR_W  current micro-PC.
- int_ack  out  1  interrupt-taken pulse.
- halted  out  1  sequencer in HALT.
- stack_err  out  1  sticky stack overflow/underflow flag.
- sp  out  clog2(STACK_DEPTH+1)  stack occupancy.

Behaviour:
- Microword fields:
  - [UADDR_W-1:0] = NXT (next address).
  - [UADDR_W+2:UADDR_W] = SEQ op.
  - [UW-1:UADDR_W+3] = control bits.
- ctrl = control field of store[upc]. It is combinational from the registered upc; store read is asynchronous.
- Reset (rst high at posedge):
  - upc=0, sp=0, stack_err=0, int_ack=0, halted=0.
  - Table contents are NOT cleared; rst has priority over everything.
- Each non-stalled cycle, upc is updated by SEQ op:
  - 000 NEXT: upc<=NXT.
  - 001 DISP_OP: upc<=optab[opcode].
  - 010 DISP_CC: upc<=cctab[cmp].
  - 011 DISP_INT: if int_req then upc<=intvec and int_ack<=1, else upc<=NXT.
  - 100 CALL: push (upc+1) mod 2**UADDR_W, then upc<=NXT.
  - 101 RET: pop, upc<=popped value.
  - 110 BR_CC: if cmp!=0 then upc<=NXT, else upc<=upc+1.
  - 111 HALT: upc holds; halted=1 combinationally while SEQ==111. Exit only by rst, or by a prog write changing the word at upc.
- int_ack: registered, high for exactly the one cycle in which upc==intvec after a taken DISP_INT; 0 otherwise.
- Stack boundary cases:
  - CALL with sp==STACK_DEPTH: jump still taken, push dropped, stack_err<=1, sp unchanged.
  - RET with sp==0: upc<=0, stack_err<=1.
  - stack_err stays set until rst.
- stall=1: upc, sp, stack and int_ack-generation frozen; ctrl continues to reflect store[upc]. A DISP_INT under stall is not taken until the stall releases, and int_req is sampled on the release cycle.
- Program writes:
  - A write takes effect at the posedge.
  - Reads that cycle see old contents; ctrl changes the next cycle if the written address equals upc.
  - Writes are legal during stall and HALT.
  - Simultaneous rst and prog_we: the write is performed and upc reset.
- Address arithmetic wraps modulo 2**UADDR_W; upc+1 from all-ones is 0.

Test Plan:
- Load store[0]={ctrl=0x000001,NEXT,NXT=5}, store[5]={ctrl=0xABCDEF,HALT}; release rst -> cycle0 ctrl=0x000001, cycle1 upc=5, ctrl=0xABCDEF, halted=1; holds for 10 cycles.
- optab[9]=0x23, store[0]={DISP_OP}, opcode=9 -> next cycle upc=0x23. Repeat with cctab[2]=0x20, store[0]={DISP_CC}, cmp=2 -> upc=0x20.
- intvec=0x2A, store[1]={DISP_INT,NXT=3}:
  - int_req=0 -> upc=3, int_ack=0.
  - int_req=1 -> upc=0x2A with int_ack=1 for exactly one cycle.
  - stall=1 held 3 cycles at upc=1 -> upc stays 1, no ack until release.
- Nested CALL depth 4 (0->0x10->0x20->0x30->0x38) then four RETs -> upc returns 0x31, 0x21, 0x11, 1; sp 4,3,2,1,0; stack_err=0. A 5th CALL at sp=4 -> jump taken, stack_err=1, sp=4.
- RET at sp=0 -> upc=0, stack_err=1. Then assert rst mid-run at upc=0x15 with sp=2 -> next cycle upc=0, sp=0, stack_err=0, tables intact.
- Overwrite store[5] (HALT) with {NEXT,NXT=0} while halted -> halted deasserts the cycle after the write; upc=0 the following cycle.
